dmem_responder: RTL

- Responder (memory) end of the MEM-stage data-memory interface: accepts one load/store request at a time from the pipeline's MEM stage and answers after a programmable wait-state latency.
- Byte-addressed, big-endian storage.
- Supports transfer sizes of 1, 2, 4 and 8 bytes.
- Flags misaligned and out-of-range accesses instead of corrupting memory.
- Replaces the zero-latency model so stall/handshake logic in the pipeline can be exercised.

---
 rtl/dmem_pkg.sv | 46 ++++
 rtl/dmem_byte_array.sv | 46 ++++
 rtl/dmem_responder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_pkg
//  Purpose  : Shared types and helpers for the data-memory responder:
//             FSM state encoding, transfer-size constants and size helpers.
//  Revision : 1.0  initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam logic [3:0] SZ_B = 4'd1;
    localparam logic [3:0] SZ_H = 4'd2;
    localparam logic [3:0] SZ_W = 4'd4;
    localparam logic [3:0] SZ_D = 4'd8;

    // True for the four transfer sizes the memory supports.
    function automatic logic size_legal(input logic [3:0] size);
        return (size == SZ_B) || (size == SZ_H) || (size == SZ_W) || (size == SZ_D);
    endfunction

    // Byte lanes touched by a transfer; lane 0 is the byte at the base address.
    function automatic logic [7:0] lane_mask(input logic [3:0] size);
        logic [7:0] mask;
        case (size)
            SZ_B:    mask = 8'h01;
            SZ_H:    mask = 8'h03;
            SZ_W:    mask = 8'h0F;
            SZ_D:    mask = 8'hFF;
            default: mask = 8'h00;
        endcase
        return mask;
    endfunction

    // Bit distance between a right-justified value of this size and the
    // left-justified (big-endian lane 0 first) position in a 64-bit word.
    function automatic logic [6:0] justify_shift(input logic [3:0] size);
        return 7'd64 - {size, 3'b000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_byte_array.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_byte_array
//  Purpose  : 2^ADDR_BITS x 8 byte storage with eight big-endian byte lanes.
//             Lane k addresses byte base+k and maps to bits [63-8k -: 8].
//             Synchronous 8-byte read; addresses wrap modulo capacity.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_byte_array #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic [7:0]           i_wr_lanes,
    input  logic                 i_rd_en,
    input  logic [ADDR_BITS-1:0] i_base_addr,
    input  logic [63:0]          i_wr_data,
    output logic [63:0]          o_rd_data
);

    localparam int c_DEPTH = 1 << ADDR_BITS;

    logic [7:0]  r_mem [c_DEPTH];
    logic [63:0] r_rd_data;

    // Per-lane byte writes; lane 0 carries the most significant byte.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (i_wr_lanes[k]) begin
                r_mem[i_base_addr + ADDR_BITS'(k)] <= i_wr_data[63-8*k -: 8];
            end
        end
    end

    // Registered read of the eight bytes starting at the base address.
    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            for (int k = 0; k < 8; k++) begin
                r_rd_data[63-8*k -: 8] <= r_mem[i_base_addr + ADDR_BITS'(k)];
            end
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Memory end of the MEM-stage data interface. Accepts one
//             load/store at a time, answers after WAIT_CYCLES wait states,
//             and flags bad-size, misaligned and out-of-range accesses.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [3:0]  req_size,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam bit         c_HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [3:0] c_WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dmem_state_t r_state;
    dmem_state_t w_next_state;
    logic [3:0]  r_cnt;
    logic [3:0]  w_next_cnt;
    logic        w_accept;

    logic        r_write;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [3:0]  r_size;

    logic        w_eff_write;
    logic [63:0] w_eff_addr;
    logic [63:0] w_eff_wdata;
    logic [3:0]  w_eff_size;
    logic        w_eff_err;
    logic        w_enter_resp;

    logic [7:0]  w_wr_lanes;
    logic        w_rd_en;
    logic [63:0] w_arr_wdata;
    logic [63:0] w_arr_rdata;

    logic        r_resp_valid;
    logic        r_resp_err;
    logic        r_load_ok;

    // Next-state and wait-counter logic.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (c_HAS_WAIT) begin
                        w_next_state = WAIT;
                        w_next_cnt   = c_WAIT_LOAD;
                    end else begin
                        w_next_state = RESP;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = RESP;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State and counter registers; reset aborts any request in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Capture the request fields at acceptance.
    always_ff @(posedge clk) begin
        if (reset && w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_size  <= req_size;
        end
    end

    // In IDLE the request is still on the inputs (zero-wait commits on the
    // accepting edge); otherwise use the captured copy.
    assign w_eff_write = (r_state == IDLE) ? req_write : r_write;
    assign w_eff_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_eff_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
    assign w_eff_size  = (r_state == IDLE) ? req_size  : r_size;

    assign w_eff_err = !size_legal(w_eff_size)
                     || ((w_eff_addr[3:0] & (w_eff_size - 4'd1)) != 4'd0)
                     || (w_eff_addr[63:ADDR_BITS] != '0);

    // Commit point: the edge that enters RESP, unless reset is asserted.
    assign w_enter_resp = (w_next_state == RESP) && reset;
    assign w_wr_lanes   = (w_enter_resp && w_eff_write && !w_eff_err) ? lane_mask(w_eff_size) : 8'h00;
    assign w_rd_en      = w_enter_resp && !w_eff_write && !w_eff_err;
    assign w_arr_wdata  = w_eff_wdata << justify_shift(w_eff_size);

    dmem_byte_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk         (clk),
        .i_wr_lanes  (w_wr_lanes),
        .i_rd_en     (w_rd_en),
        .i_base_addr (w_eff_addr[ADDR_BITS-1:0]),
        .i_wr_data   (w_arr_wdata),
        .o_rd_data   (w_arr_rdata)
    );

    // Response flags, raised for the single RESP cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_load_ok    <= 1'b0;
        end else begin
            r_resp_valid <= w_enter_resp;
            r_resp_err   <= w_enter_resp && w_eff_err;
            r_load_ok    <= w_rd_en;
        end
    end

    assign req_ready  = (r_state == IDLE) && reset;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_load_ok ? (w_arr_rdata >> justify_shift(r_size)) : 64'd0;

endmodule
`default_nettype wire
